display_varredura: RTL and testbench
====================================

// Module: display_varredura
// PURPOSE
// - Downstream of the 4-digit BCD-to-7-segment decoder: takes its four segment patterns and time-multiplexes
//   them onto one shared segment bus with per-digit anode enables. Needed for boards with a common-bus display.
// - Double-buffered frame capture (no tearing), dead time between digits (no ghosting), frame-end strobe.
// PARAMETERS
// - DIV   50000  clk cycles per digit slot; legal range DIV >= 2
// - DEAD  16     leading cycles of each slot with anodes off; legal range 0 <= DEAD < DIV
// PORTS
// - clk            in   1  single clock; all state on rising edge
// - rst_n          in   1  asynchronous, active-low reset
// - segUnidade     in   [0:6]  units pattern, bit0 = seg a, 0 = lit
// - segDezena      in   [0:6]  tens pattern
// - segCentena     in   [0:6]  hundreds pattern
// - segMilhar      in   [0:6]  thousands pattern
// - atualiza       in   1  capture strobe: sample the four patterns this cycle
// - segmentos      out  [0:6]  shared segment bus, 0 = lit
// - anodos         out  [3:0]  digit enables, active-low; bit0 = units ... bit3 = thousands
// - frame_fim      out  1  one-cycle pulse per completed 4-digit frame
// BEHAVIOUR
// - Reset (async, rst_n=0): cnt=0, dig=0, shadow and active buffers = 7'b1111111, pendente=0,
//   segmentos=7'b1111111, anodos=4'b1111, frame_fim=0. Release: first slot starts at dig=0, cnt=0.
// - Counter: cnt runs 0..DIV-1, then wraps to 0 and dig increments 0->1->2->3->0 (wraps to 0).
// - Slot output, registered (one-cycle lag from cnt/dig): cnt < DEAD -> anodos=4'b1111, segmentos=7'b1111111;
//   cnt >= DEAD -> anodos has only bit dig at 0, segmentos=active[dig]. DEAD=0: no dead time.
// - Capture: atualiza=1 -> shadow <= inputs, pendente <= 1. Repeated strobes in one frame: last one wins.
// - Frame end = cycle with dig=3 and cnt=DIV-1. On that cycle: if atualiza=1 -> active <= inputs directly;
//   else if pendente -> active <= shadow. pendente <= 0 in both cases. frame_fim=1 the next cycle only.
// - Active buffer never changes mid-frame. Without a strobe, active keeps its value indefinitely.
// - Reset mid-slot: outputs blank immediately (async). Displayed data is lost; first frame is blank until
//   a strobe arrives and the next frame end is reached.
// - Never more than one anode low at the same time, including during reset and wrap.
// CONFIGURATION
// - BLANK_ZERO_EN defined: leading-zero suppression applied at transfer into active. Thousands blanked if its
//   pattern == 7'b0000001. Hundreds blanked if thousands is blanked and its pattern == zero. Tens blanked by
//   the same rule. Units are never blanked. Blanked digit = 7'b1111111; its anode still cycles.
// - BLANK_ZERO_EN undefined: patterns are transferred unchanged.
// STRUCTURE
// - display_pkg: SEG_BLANK=7'b1111111, SEG_ZERO=7'b0000001, digit-index constants DIG_UNI..DIG_MIL (2-bit).
// - Sub-module divisor_varredura (cnt + dig counters, inputs DIV/DEAD, outputs dig, em_dead, fim_frame).
//   Top level holds the buffers, zero-blank logic and the output registers.
// TESTING (bench with DIV=8, DEAD=2)
// - Reset: rst_n=0 mid-run -> anodos=4'b1111, segmentos=7'b1111111 with no clock edge; frame_fim=0.
// - Strobe with patterns 0/1/2/3 (units..thousands), then wait -> after the next frame end, slot0 shows
//   7'b0000001 with anodos=4'b1110 on cycles 2..7; slot3 shows 7'b0000110 with anodos=4'b0111; frame_fim every 32 cycles.
// - Mid-frame strobe to 9999 -> current frame is unchanged; 7'b0000100 on all digits from the next frame on.
// - Strobe coincident with the frame-end cycle -> new value goes active right away; pendente is left 0.
// - BLANK_ZERO_EN with 0042 -> thousands and hundreds slots show 7'b1111111, tens shows 4, units shows 2;
//   0000 -> only units shows 0.
// - Assertion over 10k cycles: $countones(~anodos) <= 1 on every cycle, and anodos=4'b1111 during dead cycles.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed 7-segment display scanner.
// Optional feature macro: BLANK_ZERO_EN (leading-zero suppression).
package display_pkg;

    // One segment pattern, active-low; MSB = seg a ... LSB = seg g.
    typedef logic [6:0] seg_t;

    // Four patterns indexed by digit position (0 = units ... 3 = thousands).
    typedef logic [3:0][6:0] frame_t;

    localparam seg_t SEG_BLANK = 7'b1111111;
    localparam seg_t SEG_ZERO  = 7'b0000001;

    localparam logic [1:0] DIG_UNI = 2'd0;
    localparam logic [1:0] DIG_DEZ = 2'd1;
    localparam logic [1:0] DIG_CEN = 2'd2;
    localparam logic [1:0] DIG_MIL = 2'd3;

    // Blank leading zeros from thousands downwards; units always stay visible.
    function automatic frame_t blank_zeros(input frame_t f);
        frame_t r;
        logic   blank_mil;
        logic   blank_cen;
        logic   blank_dez;
        r         = f;
        blank_mil = (f[DIG_MIL] == SEG_ZERO);
        blank_cen = blank_mil && (f[DIG_CEN] == SEG_ZERO);
        blank_dez = blank_cen && (f[DIG_DEZ] == SEG_ZERO);
        if (blank_mil) r[DIG_MIL] = SEG_BLANK;
        if (blank_cen) r[DIG_CEN] = SEG_BLANK;
        if (blank_dez) r[DIG_DEZ] = SEG_BLANK;
        return r;
    endfunction

endpackage

// File: rtl/display_varredura_if.sv
// Scan-timing bundle between the slot divider and the display datapath.
// dig: digit currently being scanned; em_dead: slot is in its dead-time
// prefix; fim_frame: last cycle of the last slot of a frame. All three are
// valid every cycle (no handshake: the divider free-runs, the datapath
// consumes them unconditionally).
interface display_varredura_if;
    logic [1:0] dig;
    logic       em_dead;
    logic       fim_frame;

    modport master (output dig, output em_dead, output fim_frame);
    modport slave  (input  dig, input  em_dead, input  fim_frame);
endinterface

// File: rtl/divisor_varredura.sv
// Slot divider: cnt counts 0..DIV-1 per digit slot, dig steps 0..3 per frame.
module divisor_varredura
    import display_pkg::*;
#(
    parameter int DIV  = 50000,
    parameter int DEAD = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    display_varredura_if.master         scan
);

    localparam int            CW      = $clog2(DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    dig_q, dig_d;

    // Next-state: advance the cycle counter, step the digit on slot wrap.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        dig_d = dig_q;
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            dig_d = dig_q + 2'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            dig_q <= DIG_UNI;
        end else begin
            cnt_q <= cnt_d;
            dig_q <= dig_d;
        end
    end

    // With no dead time the comparison would be constant, so skip it.
    generate
        if (DEAD == 0) begin : g_no_dead
            assign scan.em_dead = 1'b0;
        end else begin : g_dead
            assign scan.em_dead = (cnt_q < CW'(DEAD));
        end
    endgenerate

    assign scan.dig       = dig_q;
    assign scan.fim_frame = (dig_q == DIG_MIL) && (cnt_q == CNT_MAX);

endmodule

// File: rtl/display_varredura.sv
// Time-multiplexes four 7-segment patterns onto one shared segment bus with
// active-low anode enables. Double-buffered capture: strobed patterns wait in
// a shadow buffer and move to the displayed buffer only at frame end.
// Optional feature macro: BLANK_ZERO_EN (leading-zero suppression on transfer).
module display_varredura
    import display_pkg::*;
#(
    parameter int DIV  = 50000,
    parameter int DEAD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] segUnidade,
    input  logic [6:0] segDezena,
    input  logic [6:0] segCentena,
    input  logic [6:0] segMilhar,
    input  logic       atualiza,
    output logic [6:0] segmentos,
    output logic [3:0] anodos,
    output logic       frame_fim
);

    display_varredura_if scan_if ();

    divisor_varredura #(.DIV(DIV), .DEAD(DEAD)) u_divisor (
        .clk   (clk),
        .rst_n (rst_n),
        .scan  (scan_if)
    );

    frame_t entrada;
    frame_t fonte;
    frame_t carga;
    frame_t shadow_q, shadow_d;
    frame_t active_q, active_d;
    logic   pendente_q, pendente_d;
    seg_t   segmentos_q, segmentos_d;
    logic [3:0] anodos_q, anodos_d;
    logic   frame_fim_q, frame_fim_d;

    assign entrada = {segMilhar, segCentena, segDezena, segUnidade};

    // A strobe on the frame-end cycle bypasses the shadow buffer.
    assign fonte = atualiza ? entrada : shadow_q;

`ifdef BLANK_ZERO_EN
    assign carga = blank_zeros(fonte);
`else
    assign carga = fonte;
`endif

    // Buffer control: capture into shadow, transfer to active only at frame end.
    always_comb begin
        shadow_d   = shadow_q;
        pendente_d = pendente_q;
        active_d   = active_q;
        if (atualiza) begin
            shadow_d   = entrada;
            pendente_d = 1'b1;
        end
        if (scan_if.fim_frame) begin
            if (atualiza || pendente_q) active_d = carga;
            pendente_d = 1'b0;
        end
    end

    // Output decode: blank during dead time, otherwise one anode low.
    always_comb begin
        segmentos_d = SEG_BLANK;
        anodos_d    = 4'b1111;
        frame_fim_d = scan_if.fim_frame;
        if (!scan_if.em_dead) begin
            segmentos_d = active_q[scan_if.dig];
            anodos_d    = ~(4'b0001 << scan_if.dig);
        end
    end

    // Buffers and registered outputs; async reset blanks the display at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q    <= {4{SEG_BLANK}};
            active_q    <= {4{SEG_BLANK}};
            pendente_q  <= 1'b0;
            segmentos_q <= SEG_BLANK;
            anodos_q    <= 4'b1111;
            frame_fim_q <= 1'b0;
        end else begin
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            pendente_q  <= pendente_d;
            segmentos_q <= segmentos_d;
            anodos_q    <= anodos_d;
            frame_fim_q <= frame_fim_d;
        end
    end

    assign segmentos = segmentos_q;
    assign anodos    = anodos_q;
    assign frame_fim = frame_fim_q;

endmodule

// File: tb/tb_display_varredura.sv
// Directed bench for display_varredura with DIV=8, DEAD=2 (32-cycle frames).
// tick = rising edges since reset release; outputs seen after edge t show
// the slot state of cycle index t-1. Build with BLANK_ZERO_EN to cover the
// leading-zero suppression expectations.
module tb_display_varredura;

    localparam int DIV  = 8;
    localparam int DEAD = 2;

    localparam logic [6:0] BLK  = 7'b1111111;
    localparam logic [6:0] S0   = 7'b0000001;
    localparam logic [6:0] S1   = 7'b1001111;
    localparam logic [6:0] S2   = 7'b0010010;
    localparam logic [6:0] S3   = 7'b0000110;
    localparam logic [6:0] S4   = 7'b1001100;
    localparam logic [6:0] S5   = 7'b0100100;
    localparam logic [6:0] S6   = 7'b0100000;
    localparam logic [6:0] S7   = 7'b0001111;
    localparam logic [6:0] S8   = 7'b0000000;
    localparam logic [6:0] S9   = 7'b0000100;
    localparam logic [6:0] GARB = 7'b1010101;

`ifdef BLANK_ZERO_EN
    localparam logic [6:0] LZ = BLK;
`else
    localparam logic [6:0] LZ = S0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [6:0] seg_uni, seg_dez, seg_cen, seg_mil;
    logic       atualiza;
    logic [6:0] segmentos;
    logic [3:0] anodos;
    logic       frame_fim;

    int checks   = 0;
    int failures = 0;
    int tick     = 0;

    display_varredura #(.DIV(DIV), .DEAD(DEAD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .segUnidade (seg_uni),
        .segDezena  (seg_dez),
        .segCentena (seg_cen),
        .segMilhar  (seg_mil),
        .atualiza   (atualiza),
        .segmentos  (segmentos),
        .anodos     (anodos),
        .frame_fim  (frame_fim)
    );

    // Clock and edge counter.
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tick <= 0;
        else        tick <= tick + 1;
    end

    // Every-cycle checks: at most one anode low; all anodes off in dead cycles.
    always @(negedge clk) begin
        checks++;
        assert ($countones(~anodos) <= 1) else begin
            failures++;
            $error("FAIL one_anode: got %b expected at most one low", anodos);
        end
        if (tick == 0 || ((tick - 1) % DIV) < DEAD) begin
            checks++;
            assert (anodos === 4'b1111) else begin
                failures++;
                $error("FAIL dead_anodos tick=%0d: got %b expected 1111", tick, anodos);
            end
        end
    end

    task automatic chk7(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [6:0] seg,
                             input logic [3:0] an, input logic ff);
        chk7({tag, "_seg"}, segmentos, seg);
        chk4({tag, "_an"}, anodos, an);
        chk1({tag, "_ff"}, frame_fim, ff);
    endtask

    // Advance to the falling edge after rising edge number t.
    task automatic at(input int t);
        int guard;
        guard = 0;
        while (tick < t) begin
            @(negedge clk);
            guard++;
            if (guard > 20000) begin
                failures++;
                $display("FAIL wait_tick: tick=%0d never reached %0d", tick, t);
                break;
            end
        end
    endtask

    task automatic drive(input logic [6:0] u, input logic [6:0] d,
                         input logic [6:0] c, input logic [6:0] m, input logic stb);
        seg_uni  = u;
        seg_dez  = d;
        seg_cen  = c;
        seg_mil  = m;
        atualiza = stb;
    endtask

    initial begin
        drive(GARB, GARB, GARB, GARB, 1'b0);
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_out("reset", BLK, 4'b1111, 1'b0);
        rst_n = 1'b1;

        // Frame 0: nothing captured yet, display blank.
        at(4);   check_out("f0_blank", BLK, 4'b1110, 1'b0);
        at(5);   drive(S0, S1, S2, S3, 1'b1);
        at(6);   drive(GARB, GARB, GARB, GARB, 1'b0);
        at(20);  check_out("f0_unchanged", BLK, 4'b1011, 1'b0);
        at(31);  chk1("ff_before_end", frame_fim, 1'b0);
        at(32);  chk1("ff_frame0", frame_fim, 1'b1);
        at(33);  chk1("ff_one_cycle", frame_fim, 1'b0);

        // Frame 1: 0123 visible.
        at(34);  check_out("f1_dead", BLK, 4'b1111, 1'b0);
        at(35);  check_out("f1_uni_first", S0, 4'b1110, 1'b0);
        at(40);  check_out("f1_uni_last", S0, 4'b1110, 1'b0);
        at(47);  check_out("f1_dez", S1, 4'b1101, 1'b0);
        at(52);  check_out("f1_cen", S2, 4'b1011, 1'b0);
        at(59);  check_out("f1_mil", S3, 4'b0111, 1'b0);
        at(63);  chk1("ff_63", frame_fim, 1'b0);
        at(64);  chk1("ff_64", frame_fim, 1'b1);

        // Mid-frame strobe to 9999: frame 2 keeps 0123.
        at(70);  drive(S9, S9, S9, S9, 1'b1);
        at(71);  drive(GARB, GARB, GARB, GARB, 1'b0);
        at(92);  check_out("f2_still_old", S3, 4'b0111, 1'b0);
        at(96);  chk1("ff_96", frame_fim, 1'b1);
        at(100); check_out("f3_uni_9", S9, 4'b1110, 1'b0);
        at(124); check_out("f3_mil_9", S9, 4'b0111, 1'b0);

        // Strobe on the frame-end cycle goes active immediately.
        at(127); drive(S5, S6, S7, S8, 1'b1);
        at(128); drive(GARB, GARB, GARB, GARB, 1'b0);
        chk1("ff_128", frame_fim, 1'b1);
        chk1("pendente_clear", dut.pendente_q, 1'b0);
        at(132); check_out("f4_uni_5", S5, 4'b1110, 1'b0);

        // 0042 captured mid-frame 4, shown in frame 5.
        at(140); drive(S2, S4, S0, S0, 1'b1);
        at(141); drive(GARB, GARB, GARB, GARB, 1'b0);
        at(148); check_out("f4_cen_7", S7, 4'b1011, 1'b0);
        at(156); check_out("f4_mil_8", S8, 4'b0111, 1'b0);
        at(164); check_out("f5_uni_2", S2, 4'b1110, 1'b0);

        // 0000 captured mid-frame 5, shown in frame 6.
        at(170); drive(S0, S0, S0, S0, 1'b1);
        at(171); drive(GARB, GARB, GARB, GARB, 1'b0);
        at(172); check_out("f5_dez_4", S4, 4'b1101, 1'b0);
        at(180); check_out("f5_cen_lz", LZ, 4'b1011, 1'b0);
        at(188); check_out("f5_mil_lz", LZ, 4'b0111, 1'b0);
        at(196); check_out("f6_uni_0", S0, 4'b1110, 1'b0);
        at(204); check_out("f6_dez_lz", LZ, 4'b1101, 1'b0);
        at(212); check_out("f6_cen_lz", LZ, 4'b1011, 1'b0);
        at(220); check_out("f6_mil_lz", LZ, 4'b0111, 1'b0);

        // Async reset mid-slot: blank without any clock edge.
        at(222);
        #1 rst_n = 1'b0;
        #1 check_out("reset_async", BLK, 4'b1111, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        at(4);   check_out("post_reset_blank", BLK, 4'b1110, 1'b0);
        at(32);  chk1("post_reset_ff", frame_fim, 1'b1);
        at(36);  check_out("post_reset_still_blank", BLK, 4'b1110, 1'b0);
        at(40);  drive(S1, S8, S8, S8, 1'b1);
        at(41);  drive(GARB, GARB, GARB, GARB, 1'b0);
        at(68);  check_out("post_reset_uni_1", S1, 4'b1110, 1'b0);
        at(76);  check_out("post_reset_dez_8", S8, 4'b1101, 1'b0);

        // Soak with scattered strobes; the per-cycle checks keep running.
        for (int k = 1; k < 32; k++) begin
            at(100 + k * 300);
            drive(7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)),
                  7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)), 1'b1);
            at(101 + k * 300);
            drive(GARB, GARB, GARB, GARB, 1'b0);
        end
        at(10000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
